// File: rtl/color_detect_pkg.sv
// Shared definitions for the colour-detect pipeline.
//   - RGB565 field positions and 565 -> 8-bit channel expansion helpers
//   - Threshold vector slot indices (packed [5:0][7:0] threshold bundles)
//   - FSM state encoding for color_bbox
//   - Default frame geometry
package color_detect_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int XW_DEF       = 10;
  localparam int YW_DEF       = 9;
  localparam int CW_DEF       = 19;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Slot order inside a packed threshold bundle.
  localparam int TH_BMIN = 0;
  localparam int TH_BMAX = 1;
  localparam int TH_GMIN = 2;
  localparam int TH_GMAX = 3;
  localparam int TH_RMIN = 4;
  localparam int TH_RMAX = 5;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_REPORT = 1'b1
  } state_t;

  // Expansion pads with zeros (no MSB replication), so full-scale 5-bit red is 248.
  function automatic logic [7:0] expand_r(input logic [15:0] d);
    return {d[R_MSB:R_LSB], 3'b000};
  endfunction

  function automatic logic [7:0] expand_g(input logic [15:0] d);
    return {d[G_MSB:G_LSB], 2'b00};
  endfunction

  function automatic logic [7:0] expand_b(input logic [15:0] d);
    return {d[B_MSB:B_LSB], 3'b000};
  endfunction

endpackage

// File: rtl/color_threshold_cmp.sv
// Combinational 3-channel inclusive range compare.
//   i_r/i_g/i_b : 8-bit expanded channel values
//   i_th        : packed thresholds, slots per color_detect_pkg TH_* indices
//   o_hit       : 1 when every channel lies inside [min, max]
// A channel with min > max can never satisfy both compares, so it never hits.
module color_threshold_cmp
  import color_detect_pkg::*;
(
  input  logic [7:0]      i_r,
  input  logic [7:0]      i_g,
  input  logic [7:0]      i_b,
  input  logic [5:0][7:0] i_th,
  output logic            o_hit
);

  logic r_ok, g_ok, b_ok;

  assign r_ok  = (i_r >= i_th[TH_RMIN]) && (i_r <= i_th[TH_RMAX]);
  assign g_ok  = (i_g >= i_th[TH_GMIN]) && (i_g <= i_th[TH_GMAX]);
  assign b_ok  = (i_b >= i_th[TH_BMIN]) && (i_b <= i_th[TH_BMAX]);
  assign o_hit = r_ok & g_ok & b_ok;

endmodule

// File: rtl/color_bbox.sv
// Colour bounding-box detector.
// Pops RGB565 pixels from the upstream filter FIFO, classifies each against
// per-channel inclusive thresholds, streams a 1-bit mask with coordinates and
// reports the hit bounding box / hit count once per frame.
// Ports:
//   i_clk, i_rst (sync, active-high)
//   i_enable, i_flush, i_data[15:0], i_empty, o_rd   : upstream FIFO side
//   i_{r,g,b}{min,max}[7:0]                          : inclusive thresholds
//   o_mask_valid, o_mask, o_x, o_y                   : mask stream (latency 2 from o_rd)
//   o_bbox_valid, o_found, o_xmin/o_xmax, o_ymin/o_ymax, o_count : frame report
// Optional feature macro COLOR_BBOX_CENTROID_EN adds o_xsum/o_ysum (sums of
// hit coordinates, reported with o_bbox_valid).
module color_bbox
  import color_detect_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_flush,
  input  logic [15:0]   i_data,
  input  logic          i_empty,
  output logic          o_rd,
  input  logic [7:0]    i_rmin,
  input  logic [7:0]    i_rmax,
  input  logic [7:0]    i_gmin,
  input  logic [7:0]    i_gmax,
  input  logic [7:0]    i_bmin,
  input  logic [7:0]    i_bmax,
  output logic          o_mask_valid,
  output logic          o_mask,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_bbox_valid,
  output logic          o_found,
  output logic [XW-1:0] o_xmin,
  output logic [XW-1:0] o_xmax,
  output logic [YW-1:0] o_ymin,
  output logic [YW-1:0] o_ymax,
  output logic [CW-1:0] o_count
`ifdef COLOR_BBOX_CENTROID_EN
  ,
  output logic [XW+CW-1:0] o_xsum,
  output logic [YW+CW-1:0] o_ysum
`endif
);

  localparam logic [XW-1:0] XLAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLAST = YW'(V_ACTIVE - 1);

  state_t          state_q, state_d;
  logic            pend_q;                 // a pop issued last cycle: i_data valid now
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [5:0][7:0] th_q, th_d, th_in, th_use;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
  logic            pix, first_px, last_px, hit, found_d;

  logic            mv_q, mask_q, bv_q, found_q;
  logic [XW-1:0]   ox_q, rxmin_q, rxmax_q;
  logic [YW-1:0]   oy_q, rymin_q, rymax_q;
  logic [CW-1:0]   rcnt_q;

  assign th_in    = {i_rmax, i_rmin, i_gmax, i_gmin, i_bmax, i_bmin};
  // A flush in the data cycle discards the in-flight pixel.
  assign pix      = pend_q & ~i_flush;
  assign first_px = (x_q == '0) && (y_q == '0);
  assign last_px  = pix && (x_q == XLAST) && (y_q == YLAST);
  // Pixel (0,0) must already be judged with the thresholds it latches.
  assign th_use   = first_px ? th_in : th_q;

  color_threshold_cmp u_cmp (
    .i_r  (expand_r(i_data)),
    .i_g  (expand_g(i_data)),
    .i_b  (expand_b(i_data)),
    .i_th (th_use),
    .o_hit(hit)
  );

  always_comb begin
    state_d = state_q;
    o_rd    = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    th_d    = th_q;
    cnt_d   = cnt_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;

    case (state_q)
      S_RUN:    o_rd = i_enable & ~i_empty & ~i_flush & ~i_rst;
      S_REPORT: state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase

    if (pix) begin
      if (first_px) th_d = th_in;
      if (hit) begin
        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        xmin_d = (x_q < xmin_q) ? x_q : xmin_q;
        xmax_d = (x_q > xmax_q) ? x_q : xmax_q;
        ymin_d = (y_q < ymin_q) ? y_q : ymin_q;
        ymax_d = (y_q > ymax_q) ? y_q : ymax_q;
      end
      if (x_q == XLAST) begin
        x_d = '0;
        y_d = (y_q == YLAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    if (last_px) state_d = S_REPORT;
    if (i_flush) state_d = S_RUN;
  end

  // Count never wraps to zero, so non-zero means at least one hit.
  assign found_d = (cnt_d != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_RUN;
      pend_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      th_q    <= '0;
      cnt_q   <= '0;
      xmin_q  <= '1;
      xmax_q  <= '0;
      ymin_q  <= '1;
      ymax_q  <= '0;
      mv_q    <= 1'b0;
      mask_q  <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      bv_q    <= 1'b0;
      found_q <= 1'b0;
      rxmin_q <= '0;
      rxmax_q <= '0;
      rymin_q <= '0;
      rymax_q <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= o_rd;
      th_q    <= th_d;
      mv_q    <= pix;
      mask_q  <= pix & hit;
      if (pix) begin
        ox_q <= x_q;
        oy_q <= y_q;
      end
      // Report is taken from next-state accumulators so the last pixel counts;
      // it then holds until the next frame's report.
      bv_q <= last_px;
      if (last_px) begin
        found_q <= found_d;
        rxmin_q <= found_d ? xmin_d : '0;
        rxmax_q <= found_d ? xmax_d : '0;
        rymin_q <= found_d ? ymin_d : '0;
        rymax_q <= found_d ? ymax_d : '0;
        rcnt_q  <= cnt_d;
      end
      // Clearing at the last pixel (not at the end of S_REPORT) keeps a
      // next-frame pixel landing during S_REPORT correctly accounted.
      if (i_flush || last_px) begin
        x_q    <= '0;
        y_q    <= '0;
        cnt_q  <= '0;
        xmin_q <= '1;
        xmax_q <= '0;
        ymin_q <= '1;
        ymax_q <= '0;
      end else begin
        x_q    <= x_d;
        y_q    <= y_d;
        cnt_q  <= cnt_d;
        xmin_q <= xmin_d;
        xmax_q <= xmax_d;
        ymin_q <= ymin_d;
        ymax_q <= ymax_d;
      end
    end
  end

`ifdef COLOR_BBOX_CENTROID_EN
  logic [XW+CW-1:0] xsum_q, xsum_d, rxsum_q;
  logic [YW+CW-1:0] ysum_q, ysum_d, rysum_q;

  assign xsum_d = (pix & hit) ? xsum_q + (XW+CW)'(x_q) : xsum_q;
  assign ysum_d = (pix & hit) ? ysum_q + (YW+CW)'(y_q) : ysum_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      xsum_q  <= '0;
      ysum_q  <= '0;
      rxsum_q <= '0;
      rysum_q <= '0;
    end else begin
      if (last_px) begin
        rxsum_q <= xsum_d;
        rysum_q <= ysum_d;
      end
      if (i_flush || last_px) begin
        xsum_q <= '0;
        ysum_q <= '0;
      end else begin
        xsum_q <= xsum_d;
        ysum_q <= ysum_d;
      end
    end
  end

  assign o_xsum = rxsum_q;
  assign o_ysum = rysum_q;
`else
  // Centroid sums are not built in this configuration.
`endif

  assign o_mask_valid = mv_q;
  assign o_mask       = mask_q;
  assign o_x          = ox_q;
  assign o_y          = oy_q;
  assign o_bbox_valid = bv_q;
  assign o_found      = found_q;
  assign o_xmin       = rxmin_q;
  assign o_xmax       = rxmax_q;
  assign o_ymin       = rymin_q;
  assign o_ymax       = rymax_q;
  assign o_count      = rcnt_q;

endmodule

// File: tb/tb_color_bbox.sv
// Directed bench for color_bbox on a reduced 8x4 frame.
module tb_color_bbox;
  localparam int H = 8, V = 4, XW = 3, YW = 2, CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, en = 1'b0, flush = 1'b0, empty = 1'b0, rd;
  logic [15:0]   data = '0;
  logic [7:0]    rmin = 8'd0, rmax = 8'd255, gmin = 8'd0, gmax = 8'd255, bmin = 8'd0, bmax = 8'd255;
  logic          mv, mask, bv, found;
  logic [XW-1:0] ox, xmin, xmax;
  logic [YW-1:0] oy, ymin, ymax;
  logic [CW-1:0] cnt;

  color_bbox #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_flush(flush), .i_data(data),
    .i_empty(empty), .o_rd(rd),
    .i_rmin(rmin), .i_rmax(rmax), .i_gmin(gmin), .i_gmax(gmax), .i_bmin(bmin), .i_bmax(bmax),
    .o_mask_valid(mv), .o_mask(mask), .o_x(ox), .o_y(oy),
    .o_bbox_valid(bv), .o_found(found), .o_xmin(xmin), .o_xmax(xmax),
    .o_ymin(ymin), .o_ymax(ymax), .o_count(cnt)
  );

  int total = 0, bad = 0;
  int mode = 0, cyc = 0;
  bit rst_r = 1'b1, en_r = 1'b0, flush_r = 1'b0, toggle = 1'b0, flush_last = 1'b0, fl_done = 1'b0;
  int fx = 0, fy = 0, ex = 0, ey = 0, nmask = 0, nhit = 0, nrep = 0, r_nhit = 0;
  bit rd_h0 = 1'b0, rd_h1 = 1'b0, fl_h0 = 1'b0, rs_h0 = 1'b0;
  logic [7:0] ft [6];
  logic r_found;
  logic [XW-1:0] r_xmin, r_xmax;
  logic [YW-1:0] r_ymin, r_ymax;
  logic [CW-1:0] r_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pixf(input int m, input int x, input int y);
    case (m)
      1:       return (x == 5 && y == 2) ? 16'hF800 : 16'h0000;
      3:       return (x < 4) ? 16'hF800 : 16'h001F;
      default: return 16'(x * 1117 + y * 3001 + 3855);
    endcase
  endfunction

  function automatic logic exp_hit(input logic [15:0] d);
    logic [7:0] r, g, b;
    r = {d[15:11], 3'b000};
    g = {d[10:5], 2'b00};
    b = {d[4:0], 3'b000};
    return (r >= ft[0]) && (r <= ft[1]) && (g >= ft[2]) && (g <= ft[3]) &&
           (b >= ft[4]) && (b <= ft[5]);
  endfunction

  // One clock: feed popped data, drive controls, check the cycle's outputs.
  task automatic step();
    logic mv_exp;
    @(posedge clk); #1;
    cyc++;
    rst   = rst_r;
    flush = flush_r;
    if (rd_h0) begin
      data = pixf(mode, fx, fy);
      if (flush_last && fx == H-1 && fy == V-1) begin flush = 1'b1; fl_done = 1'b1; end
      if (fx == H-1) begin fx = 0; fy = (fy == V-1) ? 0 : fy + 1; end else fx++;
    end
    if (flush || rst) begin fx = 0; fy = 0; end
    empty = toggle ? (cyc % 2 == 1) : 1'b0;
    en    = en_r;
    #1;
    if (fl_h0 || rs_h0) begin ex = 0; ey = 0; nmask = 0; nhit = 0; end
    mv_exp = rd_h1 & ~fl_h0 & ~rs_h0;
    chk("mask_valid_latency", 32'(mv), 32'(mv_exp));
    if (mv === 1'b1) begin
      if (ex == 0 && ey == 0) begin
        ft[0] = rmin; ft[1] = rmax; ft[2] = gmin; ft[3] = gmax; ft[4] = bmin; ft[5] = bmax;
      end
      chk("x", 32'(ox), 32'(ex));
      chk("y", 32'(oy), 32'(ey));
      chk("mask", 32'(mask), 32'(exp_hit(pixf(mode, ex, ey))));
      nmask++;
      if (mask === 1'b1) nhit++;
      if (ex == H-1) begin ex = 0; ey = (ey == V-1) ? 0 : ey + 1; end else ex++;
    end
    if (bv === 1'b1) begin
      nrep++;
      r_found = found; r_xmin = xmin; r_xmax = xmax; r_ymin = ymin; r_ymax = ymax; r_cnt = cnt;
      r_nhit = nhit; nhit = 0; nmask = 0;
    end
    chk("rd", 32'(rd), 32'(~rst & en & ~empty & ~flush & ~bv));
    rd_h1 = rd_h0; rd_h0 = rd; fl_h0 = flush; rs_h0 = rst;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_report(input string tag);
    int n0, k;
    n0 = nrep; k = 0;
    while (nrep == n0 && k < 600) begin step(); k++; end
    chk({tag, ".reported"}, 32'(nrep - n0), 32'd1);
  endtask

  task automatic chk_rep(input string t, input int f, input int x0, input int x1,
                         input int y0, input int y1, input int c);
    chk({t, ".found"}, 32'(r_found), 32'(f));
    chk({t, ".xmin"},  32'(r_xmin),  32'(x0));
    chk({t, ".xmax"},  32'(r_xmax),  32'(x1));
    chk({t, ".ymin"},  32'(r_ymin),  32'(y0));
    chk({t, ".ymax"},  32'(r_ymax),  32'(y1));
    chk({t, ".count"}, 32'(r_cnt),   32'(c));
    chk({t, ".hits"},  32'(r_nhit),  32'(c));
  endtask

  task automatic idle_flush();
    en_r = 1'b0; run(3);
    flush_r = 1'b1; step();
    flush_r = 1'b0; step();
  endtask

  task automatic wait_nmask(input int n);
    int k;
    k = 0;
    while (nmask < n && k < 300) begin step(); k++; end
    chk("wait_nmask", 32'(nmask >= n), 32'd1);
  endtask

  task automatic chk_zero(input string t);
    chk({t, ".mask_valid"}, 32'(mv), 0);
    chk({t, ".mask"},  32'(mask), 0);
    chk({t, ".x"},     32'(ox), 0);
    chk({t, ".y"},     32'(oy), 0);
    chk({t, ".bbox_valid"}, 32'(bv), 0);
    chk({t, ".found"}, 32'(found), 0);
    chk({t, ".xmin"},  32'(xmin), 0);
    chk({t, ".xmax"},  32'(xmax), 0);
    chk({t, ".ymin"},  32'(ymin), 0);
    chk({t, ".ymax"},  32'(ymax), 0);
    chk({t, ".count"}, 32'(cnt), 0);
    chk({t, ".rd"},    32'(rd), 0);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 6; i++) ft[i] = 8'd0;
    // reset
    run(3);
    chk_zero("reset");
    rst_r = 1'b0;

    // 1: all-pass thresholds, full frame
    mode = 0; en_r = 1'b1;
    wait_report("full");
    chk_rep("full", 1, 0, H-1, 0, V-1, H*V);
    run(3);
    chk("full.hold_count", 32'(cnt), 32'(H*V));
    idle_flush();

    // 2: single red pixel at (5,2)
    mode = 1; rmin = 8'd248; rmax = 8'd255; en_r = 1'b1;
    wait_report("single");
    chk_rep("single", 1, 5, 5, 2, 2, 1);
    idle_flush();

    // 3: R min > max -> nothing hits
    mode = 0; rmin = 8'd200; rmax = 8'd100; en_r = 1'b1;
    wait_report("nohit");
    chk_rep("nohit", 0, 0, 0, 0, 0, 0);
    idle_flush();

    // 4: upstream empty every other cycle
    rmin = 8'd0; rmax = 8'd255; toggle = 1'b1; en_r = 1'b1;
    wait_report("empty_toggle");
    chk_rep("empty_toggle", 1, 0, H-1, 0, V-1, H*V);
    toggle = 1'b0;
    idle_flush();

    // 5: flush mid-frame at pixel (4,2), then a full frame
    en_r = 1'b1;
    wait_nmask(2*H + 4);
    flush_r = 1'b1; step(); flush_r = 1'b0;
    wait_report("post_flush");
    chk_rep("post_flush", 1, 0, H-1, 0, V-1, H*V);

    // 5b: flush coinciding with the last pixel suppresses the report
    flush_last = 1'b1; fl_done = 1'b0;
    for (int k = 0; k < 200 && !fl_done; k++) step();
    flush_last = 1'b0;
    chk("flush_last.hit", 32'(fl_done), 32'd1);
    n0 = nrep;
    run(6);
    chk("flush_last.no_report", 32'(nrep - n0), 32'd0);
    idle_flush();

    // 6: mid-frame threshold change only applies from next (0,0)
    mode = 3; rmin = 8'd240; rmax = 8'd255; bmin = 8'd0; bmax = 8'd7; en_r = 1'b1;
    wait_nmask(H + 2);
    rmin = 8'd0; rmax = 8'd7; bmin = 8'd240; bmax = 8'd255;
    wait_report("thr_old");
    chk_rep("thr_old", 1, 0, 3, 0, V-1, 16);
    run(10);
    en_r = 1'b0; run(5); en_r = 1'b1;   // enable low mid-frame
    wait_report("thr_new");
    chk_rep("thr_new", 1, 4, H-1, 0, V-1, 16);

    // reset mid-frame, then a clean frame
    run(10);
    rst_r = 1'b1; run(2);
    chk_zero("mid_reset");
    rst_r = 1'b0;
    wait_report("after_reset");
    chk_rep("after_reset", 1, 4, H-1, 0, V-1, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
